npu_out_arbiter: RTL

Round-robin scheduler for the NPU's single 8-bit `D_OUT` pin. Four readout sources share that pin through the output mux: output FIFO, `piso_out`, comparator result and `piso_deb`. The block grants one requester at a time for a complete burst and drives the source enables (`fifo_rd_en`, PISO load/shift). It also drives `SEL_OUT` and exposes a valid/ready byte handshake to the external consumer. It sits between the top-level FSM and the output mux/PISO/FIFO instances.

---
 rtl/npu_out_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/npu_out_arbiter.sv
// Round-robin owner of the NPU D_OUT pin: grants one readout source per burst and drives
// the FIFO read strobe, PISO load/shift enables and output mux select.
module npu_out_arbiter #(
  parameter int unsigned PISO_BYTES = 4,
  parameter int unsigned DEB_BYTES  = 12,
  parameter int unsigned FIFO_BURST = 16
) (
  input  logic       CLKEXT,
  input  logic       RST_GLO,
  input  logic [3:0] REQ,
  input  logic       READY,
  input  logic       FIFO_EMPTY,
  output logic [3:0] GNT,
  output logic       D_VALID,
  output logic [2:0] SEL_OUT,
  output logic       fifo_rd_en,
  output logic       EN_PISO_OUT,
  output logic       SHIFT_OUT,
  output logic       EN_PISO_DEB,
  output logic       SHIFT_DEB,
  output logic       BUSY
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  localparam logic [1:0] SrcFifo = 2'd0;
  localparam logic [1:0] SrcPiso = 2'd1;
  localparam logic [1:0] SrcCmp  = 2'd2;
  localparam logic [1:0] SrcDeb  = 2'd3;

  localparam logic [2:0] SelFifo = 3'b000;
  localparam logic [2:0] SelPiso = 3'b001;
  localparam logic [2:0] SelIdx  = 3'b010;
  localparam logic [2:0] SelDeb  = 3'b101;

  localparam logic [7:0] FifoLast = 8'(FIFO_BURST - 1);
  localparam logic [7:0] PisoLast = 8'(PISO_BYTES - 1);
  localparam logic [7:0] DebLast  = 8'(DEB_BYTES - 1);
  localparam logic [7:0] CmpLast  = 8'd2;

  state_e     state_q, state_d;
  logic [1:0] src_q, src_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       dvalid_q, dvalid_d;
  logic       busy_q, busy_d;
  logic       rd_q, rd_d;
  logic       en_out_q, en_out_d;
  logic       en_deb_q, en_deb_d;

  logic       arb_found;
  logic       arb_skip;
  logic [1:0] arb_win;
  logic       xfer;

  assign xfer = dvalid_q & READY;

  // An empty FIFO is passed over, but the pointer is pinned at FIFO so it gets first
  // chance once data arrives.
  always_comb begin
    arb_found = 1'b0;
    arb_skip  = 1'b0;
    arb_win   = rr_q;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = rr_q + 2'(k);
      if (!arb_found && REQ[idx]) begin
        if (idx == SrcFifo && FIFO_EMPTY) begin
          arb_skip = 1'b1;
        end else begin
          arb_found = 1'b1;
          arb_win   = idx;
        end
      end
    end
  end

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q  <= StIdle;
      src_q    <= SrcFifo;
      rr_q     <= 2'd0;
      cnt_q    <= 8'd0;
      sel_q    <= SelFifo;
      gnt_q    <= 4'd0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      en_out_q <= 1'b0;
      en_deb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      en_out_q <= en_out_d;
      en_deb_q <= en_deb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          src_d   = arb_win;
          cnt_d   = 8'd0;
          rr_d    = arb_skip ? SrcFifo : arb_win + 2'd1;
          state_d = (arb_win == SrcCmp) ? StSend : StLoad;
          unique case (arb_win)
            SrcFifo: sel_d = SelFifo;
            SrcPiso: sel_d = SelPiso;
            SrcCmp:  sel_d = SelIdx;
            default: sel_d = SelDeb;
          endcase
        end
      end
      StLoad: state_d = StSend;
      StSend: begin
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          unique case (src_q)
            SrcFifo: state_d = (cnt_q < FifoLast && !FIFO_EMPTY) ? StLoad : StIdle;
            SrcPiso: if (cnt_q == PisoLast) state_d = StIdle;
            SrcDeb:  if (cnt_q == DebLast) state_d = StIdle;
            default: begin
              if (cnt_q == CmpLast) state_d = StIdle;
              else sel_d = sel_q + 3'd1;
            end
          endcase
          if (state_d == StIdle) sel_d = SelFifo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are precomputed from the next state; shift strobes follow READY.
  always_comb begin
    gnt_d    = (state_d == StIdle) ? 4'd0 : (4'd1 << src_d);
    dvalid_d = (state_d == StSend);
    busy_d   = (state_d != StIdle);
    rd_d     = (state_d == StLoad) && (src_d == SrcFifo);
    en_out_d = (state_d == StLoad) && (src_d == SrcPiso);
    en_deb_d = (state_d == StLoad) && (src_d == SrcDeb);
    SHIFT_OUT   = xfer && (src_q == SrcPiso);
    SHIFT_DEB   = xfer && (src_q == SrcDeb);
    EN_PISO_OUT = en_out_q | SHIFT_OUT;
    EN_PISO_DEB = en_deb_q | SHIFT_DEB;
  end

  assign GNT        = gnt_q;
  assign D_VALID    = dvalid_q;
  assign SEL_OUT    = sel_q;
  assign fifo_rd_en = rd_q;
  assign BUSY       = busy_q;

endmodule
